// File: rtl/i2c_tx_sched_pkg.sv
// i2c_pkg: shared op codes, sequencer state encoding and word geometry for the I2C TX path
package i2c_pkg;
  typedef enum logic [1:0] {OP_START = 2'b00, OP_WRITE = 2'b01, OP_STOP = 2'b10} i2c_op_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_ADDR, TX_LOAD, TX_WAITW, TX_DATA, TX_STOP, TX_FIN} tx_state_e;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/i2c_tx_sched_if.sv
// i2c_tx_sched_if: CPU control/status, TX FIFO pop port and byte-engine cmd/rsp handshake; master = sequencer, slave = environment
interface i2c_tx_sched_if #(parameter int LEN_W = 8, parameter int WORD_W = 32);
  logic go;
  logic [6:0] slv_addr;
  logic [LEN_W-1:0] byte_len;
  logic busy;
  logic done;
  logic nack_err;
  logic fifo_rd_en;
  logic fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_byte;
  logic rsp_valid;
  logic rsp_nack;
  modport master(input go, slv_addr, byte_len, fifo_empty, fifo_rdata, cmd_ready, rsp_valid, rsp_nack,
                 output busy, done, nack_err, fifo_rd_en, cmd_valid, cmd_op, cmd_byte);
  modport slave(output go, slv_addr, byte_len, fifo_empty, fifo_rdata, cmd_ready, rsp_valid, rsp_nack,
                input busy, done, nack_err, fifo_rd_en, cmd_valid, cmd_op, cmd_byte);
endinterface

// File: rtl/i2c_tx_sched_word_unpack.sv
// i2c_word_unpack: holds a popped FIFO word and serves its bytes MSB first (load_i captures, adv_i steps, last_o flags byte 3)
module i2c_word_unpack
  import i2c_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_i,
  input  logic                          adv_i,
  input  logic [BYTES_PER_WORD*8-1:0]   word_i,
  output logic [7:0]                    byte_o,
  output logic                          last_o
);
  logic [BYTES_PER_WORD*8-1:0] word_q;
  logic [1:0] bidx_q;
  logic [1:0] sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      bidx_q <= '0;
    end else if (load_i) begin
      word_q <= word_i;
      bidx_q <= '0;
    end else if (adv_i) begin
      bidx_q <= bidx_q + 2'd1;
    end
  end
  assign sel = ~bidx_q;
  assign byte_o = word_q[{sel, 3'b000} +: 8];
  assign last_o = bidx_q == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/i2c_tx_sched.sv
// i2c_tx_sched: sequences START, addr+W, FIFO data bytes, STOP to the byte engine and reports done/nack (ports: clk, rst, bus master modport)
module i2c_tx_sched
  import i2c_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int WORD_W = 32
) (
  input logic           clk,
  input logic           rst,
  i2c_tx_sched_if.master bus
);
  localparam logic [2:0] IDLE  = TX_IDLE;
  localparam logic [2:0] START = TX_START;
  localparam logic [2:0] ADDR  = TX_ADDR;
  localparam logic [2:0] LOAD  = TX_LOAD;
  localparam logic [2:0] WAITW = TX_WAITW;
  localparam logic [2:0] DATA  = TX_DATA;
  localparam logic [2:0] STOP  = TX_STOP;
  localparam logic [2:0] FIN   = TX_FIN;
  logic [2:0] state_q, state_d;
  logic wait_q, wait_d;
  logic nack_q, nack_d;
  logic [6:0] addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic issue, rsp, data_byte_ok;
  logic [7:0] cur_byte;
  logic last_byte;
  // wait_q splits each command state into an issue phase and a wait-for-response phase
  assign issue = state_q == START || state_q == ADDR || state_q == DATA || state_q == STOP;
  assign rsp = wait_q && bus.rsp_valid;
  assign data_byte_ok = state_q == DATA && rsp && !bus.rsp_nack;
  assign bus.cmd_valid = issue && !wait_q;
  assign bus.cmd_op = !bus.cmd_valid ? 2'b00 : state_q == START ? OP_START : state_q == STOP ? OP_STOP : OP_WRITE;
  assign bus.cmd_byte = !bus.cmd_valid ? 8'h00 : state_q == ADDR ? {addr_q, 1'b0} : state_q == DATA ? cur_byte : 8'h00;
  assign bus.fifo_rd_en = state_q == LOAD && !bus.fifo_empty;
  assign bus.busy = state_q != IDLE && state_q != FIN;
  assign bus.done = state_q == FIN;
  assign bus.nack_err = bus.done && nack_q;
  assign wait_d = rsp ? 1'b0 : (bus.cmd_valid && bus.cmd_ready) ? 1'b1 : wait_q;
  i2c_word_unpack u_unpack (
    .clk   (clk),
    .rst   (rst),
    .load_i(state_q == WAITW),
    .adv_i (data_byte_ok),
    .word_i(bus.fifo_rdata[BYTES_PER_WORD*8-1:0]),
    .byte_o(cur_byte),
    .last_o(last_byte)
  );
  always_comb begin
    state_d = state_q;
    nack_d = nack_q;
    addr_d = addr_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (bus.go) begin
        addr_d = bus.slv_addr;
        rem_d = bus.byte_len;
        nack_d = 1'b0;
        state_d = START;
      end
      START: state_d = rsp ? ADDR : START;
      ADDR: if (rsp) begin
        nack_d = bus.rsp_nack;
        state_d = (bus.rsp_nack || rem_q == '0) ? STOP : LOAD;
      end
      LOAD: state_d = bus.fifo_empty ? LOAD : WAITW;
      WAITW: state_d = DATA;
      DATA: if (rsp) begin
        nack_d = bus.rsp_nack;
        rem_d = bus.rsp_nack ? rem_q : rem_q - 1'b1;
        state_d = (bus.rsp_nack || rem_q == LEN_W'(1)) ? STOP : last_byte ? LOAD : DATA;
      end
      STOP: state_d = rsp ? FIN : STOP;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q <= 1'b0;
      nack_q <= 1'b0;
      addr_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      nack_q <= nack_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_i2c_tx_sched.sv
// tb_i2c_tx_sched: directed and random transfers against a queue-based FIFO/byte-engine model and expected command list
module tb_i2c_tx_sched;
  import i2c_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2c_tx_sched_if #(.LEN_W(8), .WORD_W(32)) bus ();
  i2c_tx_sched #(.LEN_W(8), .WORD_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int fails = 0;
  logic [31:0] fifo_q[$];
  logic [9:0] log_q[$];
  bit hold_empty = 1'b0;
  bit no_ready = 1'b0;
  int nack_at = -1;
  int wr_idx = 0;
  int pops = 0;
  bit rd_seen = 1'b0;
  int pend = 0;
  bit pend_nack = 1'b0;
  bit held = 1'b0;
  logic [9:0] held_cmd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO and byte-engine model: changes inputs on negedge, observes what the DUT will see at the next posedge 1ns later
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_nack = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_nack = 1'b0;
      if (rd_seen && fifo_q.size() > 0) begin
        bus.fifo_rdata = fifo_q.pop_front();
        pops++;
      end
      rd_seen = 1'b0;
      bus.fifo_empty = hold_empty || fifo_q.size() == 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_nack = pend_nack;
        end
      end
      bus.cmd_ready = !no_ready && ($urandom_range(0, 2) != 0);
      #1;
      if (rst) begin
        pend = 0;
        held = 1'b0;
      end else begin
        if (bus.fifo_rd_en) begin
          chk("rd_en_while_empty", 32'(bus.fifo_empty), 0);
          rd_seen = 1'b1;
        end
        if (held) begin
          chk("cmd_valid_held", 32'(bus.cmd_valid), 1);
          chk("cmd_stable", 32'({bus.cmd_op, bus.cmd_byte}), 32'(held_cmd));
        end
        held = 1'b0;
        if (bus.cmd_valid) begin
          if (bus.cmd_ready) begin
            log_q.push_back({bus.cmd_op, bus.cmd_byte});
            pend = $urandom_range(1, 3);
            pend_nack = bus.cmd_op == OP_WRITE && wr_idx == nack_at;
            if (bus.cmd_op == OP_WRITE) wr_idx++;
          end else begin
            held = 1'b1;
            held_cmd = {bus.cmd_op, bus.cmd_byte};
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_nack_err"}, 32'(bus.nack_err), 0);
    chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 0);
    chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 0);
    chk({tag, "_cmd_op"}, 32'(bus.cmd_op), 0);
    chk({tag, "_cmd_byte"}, 32'(bus.cmd_byte), 0);
  endtask

  // nk: -1 no NACK, 0 NACK on address, k NACK on k-th data byte
  task automatic run_txn(input logic [6:0] a, input int len, input int nk, input int extra_go_at,
                         input int empty_cyc, input int nready_cyc);
    logic [9:0] exp_q[$];
    logic [31:0] words[$];
    int sent, base, exp_pops, n;
    bit got_done;
    words = fifo_q;
    base = fifo_q.size();
    exp_q.push_back({OP_START, 8'h00});
    exp_q.push_back({OP_WRITE, a, 1'b0});
    sent = 0;
    if (nk != 0)
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({OP_WRITE, 8'(words[i / 4] >> (24 - 8 * (i % 4)))});
        sent++;
        if (nk == i + 1) break;
      end
    exp_q.push_back({OP_STOP, 8'h00});
    exp_pops = (sent + 3) / 4;
    log_q.delete();
    pops = 0;
    wr_idx = 0;
    nack_at = nk;
    @(negedge clk);
    bus.go = 1'b1;
    bus.slv_addr = a;
    bus.byte_len = 8'(len);
    @(negedge clk);
    bus.go = 1'b0;
    bus.slv_addr = 7'($urandom);
    bus.byte_len = 8'($urandom);
    #1 chk("busy_after_go", 32'(bus.busy), 1);
    got_done = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(negedge clk);
      bus.go = c == extra_go_at;
      hold_empty = c < empty_cyc;
      no_ready = c < nready_cyc;
      #1;
      if (bus.done) begin
        got_done = 1'b1;
        chk("nack_err", 32'(bus.nack_err), 32'(nk >= 0 && nk <= len));
        chk("busy_in_done", 32'(bus.busy), 0);
      end
    end
    hold_empty = 1'b0;
    no_ready = 1'b0;
    chk("done_seen", 32'(got_done), 1);
    @(negedge clk);
    bus.go = 1'b0;
    #1;
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("idle_after_done", 32'(bus.busy), 0);
    chk("n_cmds", 32'(log_q.size()), 32'(exp_q.size()));
    n = log_q.size() < exp_q.size() ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("cmd%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
    chk("pops", 32'(pops), 32'(exp_pops));
    chk("fifo_left", 32'(fifo_q.size()), 32'(base - exp_pops));
  endtask

  initial begin
    int len, nk, n0;
    bit ok;
    bus.go = 1'b0;
    bus.slv_addr = '0;
    bus.byte_len = '0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check_idle_outputs("post_reset");
    fifo_q = {32'h11223344, 32'h55667788};
    run_txn(7'h50, 8, -1, -1, 0, 0);
    fifo_q = {32'hAABBCCDD, 32'hEEFF0102};
    run_txn(7'h2A, 6, -1, -1, 0, 0);
    fifo_q.delete();
    run_txn(7'h3C, 0, -1, -1, 0, 0);
    fifo_q = {32'hDEADBEEF};
    run_txn(7'h11, 4, 0, -1, 0, 0);
    fifo_q = {32'h01020304, 32'h05060708};
    run_txn(7'h22, 8, 2, -1, 0, 0);
    fifo_q = {32'hCAFEF00D, 32'h12345678};
    run_txn(7'h33, 8, -1, 8, 25, 5);
    fifo_q = {32'hA1A2A3A4, 32'hB1B2B3B4};
    log_q.delete();
    wr_idx = 0;
    nack_at = -1;
    @(negedge clk);
    bus.go = 1'b1;
    bus.slv_addr = 7'h44;
    bus.byte_len = 8'd8;
    @(negedge clk);
    bus.go = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      ok = log_q.size() >= 4;
    end
    chk("reached_data", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    n0 = log_q.size();
    ok = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1 ok = ok | bus.done | bus.busy | bus.cmd_valid;
    end
    chk("idle_after_abort", 32'(ok), 0);
    chk("no_stop_after_abort", 32'(log_q.size()), 32'(n0));
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 12);
      nk = $urandom_range(0, 2) == 0 ? $urandom_range(0, len) : -1;
      fifo_q.delete();
      for (int w = 0; w < (len + 3) / 4 + 1; w++) fifo_q.push_back($urandom);
      run_txn(7'($urandom), len, nk, $urandom_range(0, 30), $urandom_range(0, 20), $urandom_range(0, 6));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
